// File: rtl/pc_sequencer.sv
// Program-address sequencer: 12-bit PC with increment/jump/call/return and a
// small hardware return-address stack. All outputs are registered.
module pc_sequencer #(
    parameter int unsigned        ADDR_W       = 12,
    parameter int unsigned        STACK_DEPTH  = 8,
    parameter logic [ADDR_W-1:0]  RESET_VECTOR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              stall,
    input  logic              jump,
    input  logic              call,
    input  logic              ret,
    input  logic [ADDR_W-1:0] target_addr,
    output logic [ADDR_W-1:0] pc_out,
    output logic              stack_full,
    output logic              stack_empty,
    output logic              stack_err
);

    localparam int unsigned IdxW = $clog2(STACK_DEPTH);
    localparam int unsigned SpW  = IdxW + 1;
    localparam logic [SpW-1:0] SpFull = SpW'(STACK_DEPTH);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [SpW-1:0]    sp_q, sp_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              err_q, err_d;
    logic              push;

    logic [ADDR_W-1:0] stack_q [STACK_DEPTH];

    logic [ADDR_W-1:0] pc_inc;
    logic [IdxW-1:0]   push_idx;
    logic [IdxW-1:0]   top_idx;
    logic [SpW-1:0]    sp_dec;

    assign pc_inc   = pc_q + ADDR_W'(1);
    assign sp_dec   = sp_q - SpW'(1);
    assign push_idx = sp_q[IdxW-1:0];
    assign top_idx  = sp_dec[IdxW-1:0];

    // Next-state: stall > ret > call > jump > en > hold.
    always_comb begin
        pc_d  = pc_q;
        sp_d  = sp_q;
        err_d = err_q;
        push  = 1'b0;
        if (stall) begin
            pc_d = pc_q;
        end else if (ret) begin
            if (!empty_q) begin
                pc_d = stack_q[top_idx];
                sp_d = sp_dec;
            end else begin
                // Underflow still advances so the program does not lock up.
                err_d = 1'b1;
                pc_d  = pc_inc;
            end
        end else if (call) begin
            pc_d = target_addr;
            if (!full_q) begin
                push = 1'b1;
                sp_d = sp_q + SpW'(1);
            end else begin
                err_d = 1'b1;
            end
        end else if (jump) begin
            pc_d = target_addr;
        end else if (en) begin
            pc_d = pc_inc;
        end
        full_d  = (sp_d == SpFull);
        empty_d = (sp_d == '0);
    end

    // PC, stack pointer and flag registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_VECTOR;
            sp_q    <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            sp_q    <= sp_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            err_q   <= err_d;
        end
    end

    // Return-address storage; contents need no reset since sp gates reads.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            stack_q[push_idx] <= pc_inc;
        end
    end

    assign pc_out      = pc_q;
    assign stack_full  = full_q;
    assign stack_empty = empty_q;
    assign stack_err   = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: one task per scenario, inline checks.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        stall = 1'b0;
    logic        jump = 1'b0;
    logic        call = 1'b0;
    logic        ret = 1'b0;
    logic [11:0] target_addr = '0;
    logic [11:0] pc_out;
    logic        stack_full;
    logic        stack_empty;
    logic        stack_err;

    int errors = 0;
    int checks = 0;

    pc_sequencer #(
        .ADDR_W(12),
        .STACK_DEPTH(8),
        .RESET_VECTOR(12'h000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .stall(stall),
        .jump(jump),
        .call(call),
        .ret(ret),
        .target_addr(target_addr),
        .pc_out(pc_out),
        .stack_full(stack_full),
        .stack_empty(stack_empty),
        .stack_err(stack_err)
    );

    always #5 clk = ~clk;

    // Apply one cycle of requests, sample 1 time unit after the edge.
    task automatic cyc(input logic e, input logic s, input logic j, input logic c,
                       input logic r, input logic [11:0] t);
        en = e; stall = s; jump = j; call = c; ret = r; target_addr = t;
        @(posedge clk);
        #1;
        en = 0; stall = 0; jump = 0; call = 0; ret = 0; target_addr = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [11:0] exp_pc;
        do_reset();
        checks++;
        if (pc_out !== 12'h000) begin
            errors++; $display("FAIL reset_pc: got %h want %h", pc_out, 12'h000);
        end
        checks++;
        if ({stack_empty, stack_full, stack_err} !== 3'b100) begin
            errors++;
            $display("FAIL reset_flags: got e/f/err=%b%b%b want 100",
                     stack_empty, stack_full, stack_err);
        end
        for (int i = 1; i <= 5; i++) begin
            cyc(1, 0, 0, 0, 0, 12'h000);
            exp_pc = 12'(i);
            checks++;
            if (pc_out !== exp_pc) begin
                errors++; $display("FAIL incr_%0d: got %h want %h", i, pc_out, exp_pc);
            end
        end
        checks++;
        if (stack_empty !== 1'b1 || stack_err !== 1'b0) begin
            errors++;
            $display("FAIL incr_flags: got empty=%b err=%b want 1 0", stack_empty, stack_err);
        end
    endtask

    task automatic test_wrap_stall();
        cyc(0, 0, 1, 0, 0, 12'hFFE);
        checks++;
        if (pc_out !== 12'hFFE) begin
            errors++; $display("FAIL wrap_jump: got %h want FFE", pc_out);
        end
        cyc(1, 0, 0, 0, 0, 12'h000);
        checks++;
        if (pc_out !== 12'hFFF) begin
            errors++; $display("FAIL wrap_inc1: got %h want FFF", pc_out);
        end
        cyc(1, 1, 0, 0, 0, 12'h000);
        checks++;
        if (pc_out !== 12'hFFF) begin
            errors++; $display("FAIL wrap_stall: got %h want FFF", pc_out);
        end
        cyc(1, 0, 0, 0, 0, 12'h000);
        checks++;
        if (pc_out !== 12'h000 || stack_err !== 1'b0) begin
            errors++;
            $display("FAIL wrap_zero: got pc=%h err=%b want 000 0", pc_out, stack_err);
        end
    endtask

    task automatic test_call_ret();
        do_reset();
        cyc(0, 0, 1, 0, 0, 12'h010);
        cyc(0, 0, 0, 1, 0, 12'h100);
        checks++;
        if (pc_out !== 12'h100 || stack_empty !== 1'b0) begin
            errors++;
            $display("FAIL call1: got pc=%h empty=%b want 100 0", pc_out, stack_empty);
        end
        cyc(0, 0, 0, 1, 0, 12'h200);
        checks++;
        if (pc_out !== 12'h200) begin
            errors++; $display("FAIL call2: got %h want 200", pc_out);
        end
        cyc(0, 0, 0, 0, 1, 12'h000);
        checks++;
        if (pc_out !== 12'h101) begin
            errors++; $display("FAIL ret1: got %h want 101", pc_out);
        end
        cyc(0, 0, 0, 0, 1, 12'h000);
        checks++;
        if (pc_out !== 12'h011 || stack_empty !== 1'b1 || stack_err !== 1'b0) begin
            errors++;
            $display("FAIL ret2: got pc=%h empty=%b err=%b want 011 1 0",
                     pc_out, stack_empty, stack_err);
        end
    endtask

    task automatic test_overflow();
        logic [11:0] pushed [8];
        logic [11:0] pc_model;
        logic [11:0] tgt;
        do_reset();
        pc_model = 12'h000;
        for (int i = 0; i < 8; i++) begin
            pushed[i] = pc_model + 12'h001;
            tgt = 12'h300 + 12'(i);
            cyc(0, 0, 0, 1, 0, tgt);
            pc_model = tgt;
        end
        checks++;
        if (pc_out !== 12'h307 || stack_full !== 1'b1 || stack_err !== 1'b0) begin
            errors++;
            $display("FAIL ovf_fill: got pc=%h full=%b err=%b want 307 1 0",
                     pc_out, stack_full, stack_err);
        end
        cyc(0, 0, 0, 1, 0, 12'h308);
        checks++;
        if (pc_out !== 12'h308 || stack_full !== 1'b1 || stack_err !== 1'b1) begin
            errors++;
            $display("FAIL ovf_9th: got pc=%h full=%b err=%b want 308 1 1",
                     pc_out, stack_full, stack_err);
        end
        for (int i = 7; i >= 0; i--) begin
            cyc(0, 0, 0, 0, 1, 12'h000);
            checks++;
            if (pc_out !== pushed[i]) begin
                errors++; $display("FAIL ovf_pop_%0d: got %h want %h", i, pc_out, pushed[i]);
            end
        end
        checks++;
        if (stack_empty !== 1'b1 || stack_full !== 1'b0 || stack_err !== 1'b1) begin
            errors++;
            $display("FAIL ovf_end: got empty=%b full=%b err=%b want 1 0 1",
                     stack_empty, stack_full, stack_err);
        end
    endtask

    task automatic test_underflow();
        do_reset();
        cyc(0, 0, 0, 0, 1, 12'h000);
        checks++;
        if (pc_out !== 12'h001 || stack_err !== 1'b1 || stack_empty !== 1'b1) begin
            errors++;
            $display("FAIL udf_ret: got pc=%h err=%b empty=%b want 001 1 1",
                     pc_out, stack_err, stack_empty);
        end
        cyc(0, 0, 1, 0, 0, 12'h050);
        checks++;
        if (pc_out !== 12'h050 || stack_err !== 1'b1) begin
            errors++;
            $display("FAIL udf_sticky: got pc=%h err=%b want 050 1", pc_out, stack_err);
        end
    endtask

    task automatic test_priority();
        do_reset();
        cyc(0, 0, 1, 0, 0, 12'h020);
        cyc(1, 1, 1, 1, 1, 12'h0A0);
        checks++;
        if (pc_out !== 12'h020 || stack_empty !== 1'b1 || stack_err !== 1'b0) begin
            errors++;
            $display("FAIL prio_stall: got pc=%h empty=%b err=%b want 020 1 0",
                     pc_out, stack_empty, stack_err);
        end
        cyc(0, 0, 1, 1, 0, 12'h0A0);
        checks++;
        if (pc_out !== 12'h0A0 || stack_empty !== 1'b0) begin
            errors++;
            $display("FAIL prio_calljump: got pc=%h empty=%b want 0A0 0", pc_out, stack_empty);
        end
        cyc(0, 0, 0, 0, 1, 12'h000);
        checks++;
        if (pc_out !== 12'h021) begin
            errors++; $display("FAIL prio_tos: got %h want 021", pc_out);
        end
        // ret+call together: ret wins, nothing pushed.
        cyc(0, 0, 0, 1, 0, 12'h0B0);
        cyc(0, 0, 0, 1, 1, 12'h0C0);
        checks++;
        if (pc_out !== 12'h022 || stack_empty !== 1'b1 || stack_err !== 1'b0) begin
            errors++;
            $display("FAIL prio_retcall: got pc=%h empty=%b err=%b want 022 1 0",
                     pc_out, stack_empty, stack_err);
        end
    endtask

    task automatic test_mid_reset();
        cyc(0, 0, 0, 1, 0, 12'h0D0);
        do_reset();
        checks++;
        if (pc_out !== 12'h000 || stack_empty !== 1'b1) begin
            errors++;
            $display("FAIL midrst: got pc=%h empty=%b want 000 1", pc_out, stack_empty);
        end
        cyc(0, 0, 0, 0, 1, 12'h000);
        checks++;
        if (pc_out !== 12'h001 || stack_err !== 1'b1) begin
            errors++;
            $display("FAIL midrst_udf: got pc=%h err=%b want 001 1", pc_out, stack_err);
        end
    endtask

    initial begin
        test_reset();
        test_wrap_stall();
        test_call_ret();
        test_overflow();
        test_underflow();
        test_priority();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-address sequencer for the 16-bit CPU.
- Holds the 12-bit program counter and computes the next fetch address from increment, jump, call and return requests.
- Keeps a small hardware return-address stack for call and return.
- pc_out drives the fetch-side input of the registered address mux, which selects between fetch and data addresses for memory.

Parameters:
ADDR_W, 12, width of the program counter and all address ports
STACK_DEPTH, 8, number of return-address stack entries (power of 2, ≥2)
RESET_VECTOR, 12'h000, value loaded into PC on reset

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
en  input  1  advance request: PC <= PC+1 when no higher-priority request is active
stall  input  1  freeze PC and stack for this cycle
jump  input  1  load PC from target_addr
call  input  1  push return address PC+1 and load PC from target_addr
ret  input  1  pop the top of stack into PC
target_addr  input  ADDR_W  jump/call destination
pc_out  output  ADDR_W  current program counter (registered)
stack_full  output  1  stack holds STACK_DEPTH entries
stack_empty  output  1  stack holds 0 entries
stack_err  output  1  sticky flag for overflow or underflow, cleared only by rst

Behaviour:
- All outputs come from registers. There is no combinational path from inputs to outputs.
- Reset (rst=1 at posedge), which overrides every other input:
  - pc_out <= RESET_VECTOR
  - stack pointer <= 0, stack_empty <= 1, stack_full <= 0, stack_err <= 0
  - stack contents are don't-care
- Priority per cycle, evaluated at posedge when rst=0: stall > ret > call > jump > en > hold.
  - stall=1: PC, stack pointer and flags unchanged. Requests presented in that cycle are dropped, not queued.
  - ret=1 with stack not empty: PC <= stack[sp-1], sp <= sp-1.
  - ret=1 with stack empty: stack_err <= 1, PC <= PC+1, sp unchanged.
  - call=1 with stack not full: stack[sp] <= PC+1, sp <= sp+1, PC <= target_addr.
  - call=1 with stack full: no push, existing entries preserved, stack_err <= 1, PC <= target_addr.
  - jump=1: PC <= target_addr, stack untouched.
  - en=1: PC <= PC+1.
  - none of the above: PC holds.
- Latency: one cycle. A request at edge N is visible on pc_out after edge N.
- Arithmetic:
  - PC+1 is modulo 2^ADDR_W: 12'hFFF+1 = 12'h000. No flag is raised on wrap.
  - The pushed return address wraps the same way.
- Simultaneous requests:
  - Lower-priority requests are ignored entirely. Example: call+jump both asserted acts as call only.
  - ret+call in the same cycle acts as ret only. No push happens.
- Stack pointer:
  - width is clog2(STACK_DEPTH)+1, range 0..STACK_DEPTH
  - stack_full = (sp == STACK_DEPTH), stack_empty = (sp == 0)
  - flags are registered and update in the same cycle as sp
- stack_err stays asserted from the first error until rst. Later successful operations do not clear it.
- Reset asserted mid-sequence discards all stack contents. The next ret after reset is an underflow.

Test Plan:
- Reset and increment: rst for 2 cycles, then en=1 for 5 cycles -> pc_out 000, 001, 002, 003, 004, 005; stack_empty=1; stack_err=0.
- Wrap and stall: jump to FFE, then en for 3 cycles with stall=1 on the second -> pc_out FFE, FFF, FFF, 000; stack_err stays 0.
- Call/return nesting:
  - at PC=010, call target 100; at PC=100, call target 200; then ret, ret
  - required pc_out sequence: 100, 200, 101, 011
  - stack_empty=1 at the end
- Overflow:
  - STACK_DEPTH=8, issue 9 calls to targets 300..308
  - 9th call: stack_full=1, stack_err=1, PC=308, sp stays 8
  - 8 rets then return the first 8 pushed return addresses (each call's PC+1) in reverse order
- Underflow: after reset, ret -> pc_out 001, stack_err=1; a following jump to 050 -> pc_out 050, stack_err still 1.
- Priority: stall+ret+call+jump together -> no change; next cycle call+jump (target 0A0) at PC=020 -> PC=0A0, top of stack=021.
